icosoc_mod_trigrec2: RTL and testbench

//  Parametrised trigger/event recorder on the icosoc peripheral bus, single clk domain.
//  NUM_TRIGGERS mask/value/edge triggers drive a run-control FSM; while RUNNING, every input change
//  is timestamped into an on-chip FIFO that the CPU drains over the bus.

---
 rtl/icosoc_mod_trigrec2.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_icosoc_mod_trigrec2.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icosoc_mod_trigrec2.sv
// ---------------------------------------------------------------------------
// icosoc_mod_trigrec2 -- trigger / event recorder peripheral for the icosoc bus
//
// The IO inputs pass through a 2-FF synchroniser. NUM_TRIGGERS
// mask/value/edge comparators drive a run-control FSM
// (IDLE -> ARMED -> RUNNING -> STOPPED). While RUNNING, every change of the
// synchronised inputs is pushed as {io, timestamp} into an on-chip FIFO. The
// CPU drains that FIFO over the bus.
//
// Optional feature macro: TRIGREC2_STOP_ON_FULL_EN
//   defined   : a push attempt into a full FIFO (without a same-cycle pop)
//               forces the FSM to STOPPED. The entry is dropped and ovf counts it.
//   undefined : recording continues. Entries are dropped while the FIFO is full.
//
// Ports
//   clk        in   1          system clock, all logic on the rising edge
//   resetn     in   1          asynchronous active-low reset
//   ctrl_wr    in   4          bus write strobes (any bit set = write)
//   ctrl_rd    in   1          bus read strobe
//   ctrl_addr  in   16         bus address
//   ctrl_wdat  in   32         bus write data
//   ctrl_rdat  out  32         bus read data, valid while ctrl_done=1
//   ctrl_done  out  1          one-cycle bus completion pulse
//   IO         in   IO_LENGTH  sampled inputs
//
// Register map
//   0x000 R   io_cur
//   0x004 W   [0] arm, [1] stop, [2] fifo clear
//   0x004 R   {ovf[15:0], 3'b0, last_trig[4:0], 4'b0, full, nempty, state[1:0]}
//   0x008 R   timestamp
//   0x010 R   FIFO head timestamp (no pop)
//   0x014 R   FIFO head io value, pops the entry
//   0x100+16n +0 mask, +4 value, +8 edge, +C action ([1:0] kind, [2] enable)
// ---------------------------------------------------------------------------
module icosoc_mod_trigrec2 #(
   parameter int CLOCK_FREQ_HZ = 0,
   parameter int IO_LENGTH     = 16,
   parameter int NUM_TRIGGERS  = 4,
   parameter int TS_WIDTH      = 32,
   parameter int FIFO_DEPTH    = 256
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [3:0]           ctrl_wr,
   input  logic                 ctrl_rd,
   input  logic [15:0]          ctrl_addr,
   input  logic [31:0]          ctrl_wdat,
   output logic [31:0]          ctrl_rdat,
   output logic                 ctrl_done,
   input  logic [IO_LENGTH-1:0] IO
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = IO_LENGTH + TS_WIDTH;

   localparam logic [1:0] ACT_START  = 2'd1;
   localparam logic [1:0] ACT_STOP   = 2'd2;
   localparam logic [1:0] ACT_RECORD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RUNNING = 2'd2,
      ST_STOPPED = 2'd3
   } state_t;

   // Input synchroniser and change detection
   logic [IO_LENGTH-1:0] io_meta_q, io_meta_d;
   logic [IO_LENGTH-1:0] io_cur_q,  io_cur_d;
   logic [IO_LENGTH-1:0] io_prev_q, io_prev_d;
   logic                 io_change;

   // Trigger configuration
   logic [IO_LENGTH-1:0] trig_mask_q   [NUM_TRIGGERS];
   logic [IO_LENGTH-1:0] trig_mask_d   [NUM_TRIGGERS];
   logic [IO_LENGTH-1:0] trig_value_q  [NUM_TRIGGERS];
   logic [IO_LENGTH-1:0] trig_value_d  [NUM_TRIGGERS];
   logic [IO_LENGTH-1:0] trig_edge_q   [NUM_TRIGGERS];
   logic [IO_LENGTH-1:0] trig_edge_d   [NUM_TRIGGERS];
   logic [2:0]           trig_action_q [NUM_TRIGGERS];
   logic [2:0]           trig_action_d [NUM_TRIGGERS];

   // Run control
   state_t              state_q, state_d;
   logic [TS_WIDTH-1:0] ts_q, ts_d;
   logic [4:0]          last_trig_q, last_trig_d;
   logic                hit;
   logic [4:0]          hit_idx;
   logic [1:0]          hit_act;
   logic                push_req;

   // Event FIFO
   logic [EW-1:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]         count_q, count_d;
   logic [15:0]         ovf_q, ovf_d;
   logic                fifo_full, fifo_nempty;
   logic                push_ok, drop, mem_we;
   logic [EW-1:0]       head_entry;
   logic [IO_LENGTH-1:0] head_io;
   logic [TS_WIDTH-1:0] head_ts;

   // Bus
   logic                req, wr_en, rd_en;
   logic                trig_reg_sel, ctrl_sel;
   logic                arm_wr, stop_wr, fifo_clr, pop;
   logic [31:0]         status_word, rd_word;
   logic [31:0]         rdat_q, rdat_d;
   logic                done_q, done_d;
   logic                unused_bits;

   assign unused_bits = ^{ctrl_wdat, 32'(CLOCK_FREQ_HZ)};

   assign ctrl_rdat = rdat_q;
   assign ctrl_done = done_q;

   assign io_change   = (io_cur_q != io_prev_q);
   assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_nempty = (count_q != '0);
   assign head_entry  = mem_q[rd_ptr_q];
   assign head_io     = head_entry[EW-1:TS_WIDTH];
   assign head_ts     = head_entry[TS_WIDTH-1:0];
   assign mem_we      = push_ok;
   assign status_word = {ovf_q, 3'b000, last_trig_q, 4'b0000,
                         fifo_full, fifo_nempty, state_q};

   // SB_IO in plain-input mode is a pass-through, so the pins feed the
   // synchroniser directly.
   always_comb begin
      io_meta_d = IO;
      io_cur_d  = io_meta_q;
      io_prev_d = io_cur_q;
   end

   // Bus decode and read mux. A request is taken only when ctrl_done is low,
   // so the strobe still held during the done cycle is not seen twice.
   always_comb begin
      req          = ((|ctrl_wr) | ctrl_rd) & ~done_q;
      wr_en        = req & (|ctrl_wr);
      rd_en        = req & ctrl_rd;
      ctrl_sel     = (ctrl_addr == 16'h0004);
      trig_reg_sel = (ctrl_addr[15:8] == 8'h01) && (ctrl_addr[1:0] == 2'b00);
      arm_wr       = wr_en & ctrl_sel & ctrl_wdat[0];
      stop_wr      = wr_en & ctrl_sel & ctrl_wdat[1];
      fifo_clr     = wr_en & ctrl_sel & ctrl_wdat[2];
      pop          = rd_en & (ctrl_addr == 16'h0014) & fifo_nempty;
      done_d       = req;

      rd_word = '0;
      case (ctrl_addr)
         16'h0000: rd_word = 32'(io_cur_q);
         16'h0004: rd_word = status_word;
         16'h0008: rd_word = 32'(ts_q);
         16'h0010: rd_word = fifo_nempty ? 32'(head_ts) : '0;
         16'h0014: rd_word = fifo_nempty ? 32'(head_io) : '0;
         default: begin
            if (trig_reg_sel) begin
               for (int i = 0; i < NUM_TRIGGERS; i++) begin
                  if (ctrl_addr[7:4] == 4'(i)) begin
                     case (ctrl_addr[3:2])
                        2'd0: rd_word = 32'(trig_mask_q[i]);
                        2'd1: rd_word = 32'(trig_value_q[i]);
                        2'd2: rd_word = 32'(trig_edge_q[i]);
                        default: rd_word = 32'(trig_action_q[i]);
                     endcase
                  end
               end
            end
         end
      endcase
      rdat_d = rd_en ? rd_word : '0;
   end

   // Trigger register writes
   always_comb begin
      trig_mask_d   = trig_mask_q;
      trig_value_d  = trig_value_q;
      trig_edge_d   = trig_edge_q;
      trig_action_d = trig_action_q;
      for (int i = 0; i < NUM_TRIGGERS; i++) begin
         if (wr_en && trig_reg_sel && (ctrl_addr[7:4] == 4'(i))) begin
            case (ctrl_addr[3:2])
               2'd0: trig_mask_d[i]   = ctrl_wdat[IO_LENGTH-1:0];
               2'd1: trig_value_d[i]  = ctrl_wdat[IO_LENGTH-1:0];
               2'd2: trig_edge_d[i]   = ctrl_wdat[IO_LENGTH-1:0];
               default: trig_action_d[i] = ctrl_wdat[2:0];
            endcase
         end
      end
   end

   // Trigger match. Scanning from the top down lets the lowest matching
   // index overwrite the result, so the lowest index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_act = '0;
      for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
         if (trig_action_q[i][2] &&
             (((io_cur_q ^ trig_value_q[i]) & ~trig_mask_q[i]) == '0) &&
             (((io_cur_q ^ io_prev_q) & trig_edge_q[i]) == trig_edge_q[i])) begin
            hit     = 1'b1;
            hit_idx = 5'(i);
            hit_act = trig_action_q[i][1:0];
         end
      end
   end

   // Run-control FSM, timestamp and FIFO bookkeeping
   always_comb begin
      state_d     = state_q;
      ts_d        = (state_q == ST_RUNNING) ? ts_q + TS_WIDTH'(1) : ts_q;
      last_trig_d = hit ? hit_idx : last_trig_q;
      push_req    = 1'b0;

      // An arm write overrides any trigger action in the same cycle.
      if (arm_wr) begin
         state_d = ST_ARMED;
         ts_d    = '0;
      end else begin
         if ((state_q == ST_ARMED) && hit && (hit_act == ACT_START)) begin
            state_d  = ST_RUNNING;
            push_req = 1'b1;
         end
         if (state_q == ST_RUNNING) begin
            if (io_change) push_req = 1'b1;
            if ((hit && (hit_act == ACT_STOP)) || stop_wr) begin
               state_d  = ST_STOPPED;
               push_req = 1'b1;
            end
         end
         if (hit && (hit_act == ACT_RECORD)) push_req = 1'b1;
      end

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      push_ok  = 1'b0;
      drop     = 1'b0;
      if (fifo_clr) begin
         // Clear wins over a push or pop in the same cycle.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = '0;
      end else begin
         // A pop in the same cycle frees a slot, so a full FIFO still accepts.
         push_ok = push_req & (~fifo_full | pop);
         drop    = push_req & fifo_full & ~pop;
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
         else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
         if (drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
`ifdef TRIGREC2_STOP_ON_FULL_EN
         if (drop) state_d = ST_STOPPED;
`endif
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         io_meta_q   <= '0;
         io_cur_q    <= '0;
         io_prev_q   <= '0;
         for (int i = 0; i < NUM_TRIGGERS; i++) begin
            trig_mask_q[i]   <= '0;
            trig_value_q[i]  <= '0;
            trig_edge_q[i]   <= '0;
            trig_action_q[i] <= '0;
         end
         state_q     <= ST_IDLE;
         ts_q        <= '0;
         last_trig_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= '0;
         rdat_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         io_meta_q     <= io_meta_d;
         io_cur_q      <= io_cur_d;
         io_prev_q     <= io_prev_d;
         trig_mask_q   <= trig_mask_d;
         trig_value_q  <= trig_value_d;
         trig_edge_q   <= trig_edge_d;
         trig_action_q <= trig_action_d;
         state_q       <= state_d;
         ts_q          <= ts_d;
         last_trig_q   <= last_trig_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         rdat_q        <= rdat_d;
         done_q        <= done_d;
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= {io_cur_q, ts_q};
   end

endmodule

// File: tb/tb_icosoc_mod_trigrec2.sv
module tb_icosoc_mod_trigrec2;

   localparam int IOW   = 8;
   localparam int NT    = 4;
   localparam int TSW   = 8;
   localparam int DEPTH = 4;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic [3:0]     ctrl_wr = '0;
   logic           ctrl_rd = 1'b0;
   logic [15:0]    ctrl_addr = '0;
   logic [31:0]    ctrl_wdat = '0;
   logic [31:0]    ctrl_rdat;
   logic           ctrl_done;
   logic [IOW-1:0] io = '0;

   icosoc_mod_trigrec2 #(
      .CLOCK_FREQ_HZ(0),
      .IO_LENGTH(IOW),
      .NUM_TRIGGERS(NT),
      .TS_WIDTH(TSW),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .ctrl_wr(ctrl_wr),
      .ctrl_rd(ctrl_rd),
      .ctrl_addr(ctrl_addr),
      .ctrl_wdat(ctrl_wdat),
      .ctrl_rdat(ctrl_rdat),
      .ctrl_done(ctrl_done),
      .IO(io)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int run_base = 0;

   typedef struct {
      logic [IOW-1:0] io;
      logic [TSW-1:0] ts;
   } ent_t;
   ent_t sb[$];

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] wdat;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[16];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Caller is at a negedge: drive one request and wait for its completion.
   task automatic bus_now(input bit wr, input logic [15:0] addr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
      ctrl_addr = addr;
      ctrl_wdat = wdat;
      ctrl_wr   = wr ? 4'hF : 4'h0;
      ctrl_rd   = !wr;
      @(posedge clk); #1;
      check("done_pulse", {31'b0, ctrl_done}, 32'd1);
      rdat = ctrl_rdat;
      @(negedge clk);
      ctrl_wr = '0;
      ctrl_rd = 1'b0;
      @(posedge clk); #1;
      check("done_drop", {31'b0, ctrl_done}, 32'd0);
   endtask

   task automatic bus(input bit wr, input logic [15:0] addr, input logic [31:0] wdat,
                      output logic [31:0] rdat);
      @(negedge clk);
      bus_now(wr, addr, wdat, rdat);
   endtask

   task automatic wr_reg(input logic [15:0] addr, input logic [31:0] data);
      logic [31:0] d;
      bus(1'b1, addr, data, d);
   endtask

   task automatic rd_chk(input string name, input logic [15:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      bus(1'b0, addr, 32'h0, d);
      check(name, d, exp);
   endtask

   // mode 0: not recorded, 1: start of run (ts 0), 2: recorded while running.
   // An IO edge reaches io_cur two clocks later and is recorded at the third.
   task automatic drive_io(input logic [IOW-1:0] v, input int mode);
      ent_t e;
      @(negedge clk);
      io = v;
      e.io = v;
      if (mode == 1) begin
         run_base = cyc + 3;
         e.ts = '0;
         sb.push_back(e);
      end else if (mode == 2) begin
         e.ts = TSW'(cyc + 2 - run_base);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      ent_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, nothing to compare", name);
      end else begin
         e = sb.pop_front();
         rd_chk({name, "_ts"}, 16'h0010, 32'(e.ts));
         rd_chk({name, "_io"}, 16'h0014, 32'(e.io));
      end
   endtask

   task automatic set_vec(input int i, input bit wr, input logic [15:0] addr,
                          input logic [31:0] wdat, input logic [31:0] exp, input string name);
      vecs[i].wr   = wr;
      vecs[i].addr = addr;
      vecs[i].wdat = wdat;
      vecs[i].exp  = exp;
      vecs[i].name = name;
   endtask

   initial begin
      logic [31:0] d;
      int          tgt;

      set_vec(0,  1'b1, 16'h0100, 32'hFFFF_FFFE, 32'h0, "mask0_wr");
      set_vec(1,  1'b1, 16'h0104, 32'h0000_0001, 32'h0, "value0_wr");
      set_vec(2,  1'b1, 16'h0108, 32'h0000_0001, 32'h0, "edge0_wr");
      set_vec(3,  1'b1, 16'h010C, 32'hFFFF_FFF5, 32'h0, "action0_wr");
      set_vec(4,  1'b0, 16'h0100, 32'h0, 32'h0000_00FE, "mask0_rd");
      set_vec(5,  1'b0, 16'h0104, 32'h0, 32'h0000_0001, "value0_rd");
      set_vec(6,  1'b0, 16'h0108, 32'h0, 32'h0000_0001, "edge0_rd");
      set_vec(7,  1'b0, 16'h010C, 32'h0, 32'h0000_0005, "action0_rd");
      set_vec(8,  1'b1, 16'h013C, 32'h0000_0002, 32'h0, "action3_wr");
      set_vec(9,  1'b0, 16'h013C, 32'h0, 32'h0000_0002, "action3_rd");
      set_vec(10, 1'b1, 16'h0200, 32'h0000_1234, 32'h0, "unmapped_wr");
      set_vec(11, 1'b0, 16'h0200, 32'h0, 32'h0, "unmapped_rd");
      set_vec(12, 1'b0, 16'h0140, 32'h0, 32'h0, "trig4_absent");
      set_vec(13, 1'b0, 16'h000C, 32'h0, 32'h0, "unmapped_0c");
      set_vec(14, 1'b0, 16'h0000, 32'h0, 32'h0, "io_idle");
      set_vec(15, 1'b0, 16'h0004, 32'h0, 32'h0, "status_idle");

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", {31'b0, ctrl_done}, 32'd0);
      check("rst_rdat", ctrl_rdat, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      rd_chk("rst_status", 16'h0004, 32'h0);
      rd_chk("rst_ts", 16'h0008, 32'h0);
      rd_chk("rst_empty_io", 16'h0014, 32'h0);

      // Register table
      for (int i = 0; i < $size(vecs); i++) begin
         if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdat);
         else            rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
      end

      // Arm and start on the rising edge of IO[0]
      wr_reg(16'h0004, 32'h1);
      rd_chk("armed_status", 16'h0004, 32'h1);
      drive_io(8'h01, 1);
      repeat (4) @(negedge clk);
      rd_chk("run_status", 16'h0004, 32'h6);
      rd_chk("run_io", 16'h0000, 32'h1);

      // Three changes five cycles apart
      drive_io(8'h03, 2);
      repeat (4) @(negedge clk);
      drive_io(8'h07, 2);
      repeat (4) @(negedge clk);
      drive_io(8'h06, 2);
      repeat (5) @(negedge clk);
      rd_chk("full_status", 16'h0004, 32'hE);
      for (int i = 0; i < 4; i++) drain("run_entry");
      rd_chk("empty_head_ts", 16'h0010, 32'h0);
      rd_chk("empty_head_io", 16'h0014, 32'h0);

      // Six changes into a four-entry FIFO with no reads
      for (int i = 1; i <= 6; i++) begin
         drive_io(IOW'(i * 16), (i <= 4) ? 2 : 0);
         repeat (2) @(negedge clk);
      end
      repeat (4) @(negedge clk);
`ifdef TRIGREC2_STOP_ON_FULL_EN
      rd_chk("ovf_status", 16'h0004, 32'h0001_000F);
`else
      rd_chk("ovf_status", 16'h0004, 32'h0002_000E);
`endif
      drain("ovf_entry");
      drain("ovf_entry");
      wr_reg(16'h0004, 32'h4);
      sb.delete();
`ifdef TRIGREC2_STOP_ON_FULL_EN
      rd_chk("clear_status", 16'h0004, 32'h3);
`else
      rd_chk("clear_status", 16'h0004, 32'h2);
`endif

      // trig1 (stop) and trig2 (record) fire together
      wr_reg(16'h0110, 32'hFD);
      wr_reg(16'h0114, 32'h02);
      wr_reg(16'h0118, 32'h02);
      wr_reg(16'h011C, 32'h6);
      wr_reg(16'h0120, 32'hFD);
      wr_reg(16'h0124, 32'h02);
      wr_reg(16'h0128, 32'h02);
      wr_reg(16'h012C, 32'h7);
      wr_reg(16'h0004, 32'h1);
      drive_io(8'h61, 1);
      repeat (4) @(negedge clk);
      drive_io(8'h63, 2);
      repeat (5) @(negedge clk);
      rd_chk("dual_status", 16'h0004, 32'h0000_0107);
      drain("dual_entry");
      drain("dual_entry");
      rd_chk("dual_empty", 16'h0014, 32'h0);
      drive_io(8'h62, 0);
      repeat (5) @(negedge clk);
      rd_chk("stopped_no_rec", 16'h0004, 32'h0000_0103);

      // Timestamp wrap with an 8-bit counter, 300 cycles of RUNNING
      wr_reg(16'h0004, 32'h1);
      drive_io(8'h63, 1);
      tgt = run_base + 299;
      while (cyc < tgt) @(negedge clk);
      check("stop_timing", 32'(cyc), 32'(tgt));
      bus_now(1'b1, 16'h0004, 32'h2, d);
      begin
         ent_t e;
         e.io = 8'h63;
         e.ts = TSW'(tgt - run_base);
         sb.push_back(e);
      end
      rd_chk("ts_wrap", 16'h0008, 32'd44);
      rd_chk("wrap_status", 16'h0004, 32'h7);
      drain("wrap_entry");
      drain("wrap_entry");
      wr_reg(16'h0004, 32'h1);
      rd_chk("rearm_ts", 16'h0008, 32'h0);
      rd_chk("rearm_status", 16'h0004, 32'h1);

      // Asynchronous reset while RUNNING with three entries queued
      drive_io(8'h62, 0);
      repeat (3) @(negedge clk);
      drive_io(8'h63, 1);
      repeat (3) @(negedge clk);
      drive_io(8'h73, 2);
      repeat (3) @(negedge clk);
      drive_io(8'h33, 2);
      repeat (4) @(negedge clk);
      ctrl_addr = 16'h0004;
      ctrl_rd   = 1'b1;
      @(posedge clk); #1;
      check("pre_rst_done", {31'b0, ctrl_done}, 32'd1);
      check("pre_rst_status", ctrl_rdat, 32'h6);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_done", {31'b0, ctrl_done}, 32'd0);
      check("async_rst_rdat", ctrl_rdat, 32'd0);
      @(negedge clk);
      ctrl_rd = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      sb.delete();
      rd_chk("post_rst_status", 16'h0004, 32'h0);
      rd_chk("post_rst_ts", 16'h0008, 32'h0);
      rd_chk("post_rst_action0", 16'h010C, 32'h0);
      rd_chk("post_rst_empty", 16'h0014, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
